// File: rtl/exec_trace_fifo.sv
// Commit-event trace FIFO: records register-file and data-memory writes from the core
// (up to two per cycle, reg before mem) and presents them first-word fall-through on a valid/ready port.
module exec_trace_fifo #(
   parameter int DEPTH     = 16,
   parameter bit FILTER_X0 = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     trace_en,
   input  logic [31:0]              pc,
   input  logic                     reg_we,
   input  logic [4:0]               reg_rd,
   input  logic [31:0]              reg_data,
   input  logic                     mem_we,
   input  logic [31:0]              mem_addr,
   input  logic [31:0]              mem_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [1:0]               out_kind,
   output logic [31:0]              out_pc,
   output logic [31:0]              out_addr,
   output logic [31:0]              out_data,
   output logic [15:0]              out_seq,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic [15:0]              drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
   localparam logic [1:0] KIND_REG = 2'b01;
   localparam logic [1:0] KIND_MEM = 2'b10;

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + 17'(b);
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic [15:0]   r_seq;
   logic          r_overflow;
   logic [15:0]   r_drop;

   logic [1:0]    r_kind_mem [DEPTH];
   logic [31:0]   r_pc_mem   [DEPTH];
   logic [31:0]   r_addr_mem [DEPTH];
   logic [31:0]   r_data_mem [DEPTH];
   logic [15:0]   r_seq_mem  [DEPTH];

   logic          w_empty;
   logic          w_pop;
   logic          w_reg_ev;
   logic          w_mem_ev;
   logic [CW-1:0] w_base;
   logic [CW-1:0] w_base2;
   logic          w_acc_reg;
   logic          w_acc_mem;
   logic [1:0]    w_n_acc;
   logic [1:0]    w_n_drop;
   logic [AW-1:0] w_mem_slot;
   logic [15:0]   w_mem_seq;

   assign w_empty  = (r_count == '0);
   assign w_pop    = !w_empty && out_ready;
   assign w_reg_ev = trace_en && reg_we && (FILTER_X0 ? (reg_rd != 5'd0) : 1'b1);
   assign w_mem_ev = trace_en && mem_we;

   // A same-cycle pop frees its slot before the pushes are checked, reg first then mem.
   assign w_base     = r_count - CW'(w_pop);
   assign w_acc_reg  = w_reg_ev && (w_base < LP_DEPTH);
   assign w_base2    = w_base + CW'(w_acc_reg);
   assign w_acc_mem  = w_mem_ev && (w_base2 < LP_DEPTH);
   assign w_n_acc    = {1'b0, w_acc_reg} + {1'b0, w_acc_mem};
   assign w_n_drop   = {1'b0, w_reg_ev && !w_acc_reg} + {1'b0, w_mem_ev && !w_acc_mem};
   assign w_mem_slot = r_wptr + AW'(w_acc_reg);
   assign w_mem_seq  = r_seq + 16'(w_acc_reg);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_seq      <= '0;
         r_overflow <= 1'b0;
         r_drop     <= '0;
      end else begin
         r_wptr  <= r_wptr + AW'(w_n_acc);
         r_rptr  <= r_rptr + AW'(w_pop);
         r_count <= r_count + CW'(w_n_acc) - CW'(w_pop);
         r_seq   <= r_seq + 16'(w_n_acc);
         if (w_n_drop != 2'd0) begin
            r_overflow <= 1'b1;
         end
         r_drop <= sat_add16(r_drop, w_n_drop);
      end
   end

   // Entry storage carries no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (w_acc_reg) begin
         r_kind_mem[r_wptr] <= KIND_REG;
         r_pc_mem[r_wptr]   <= pc;
         r_addr_mem[r_wptr] <= {27'b0, reg_rd};
         r_data_mem[r_wptr] <= reg_data;
         r_seq_mem[r_wptr]  <= r_seq;
      end
      if (w_acc_mem) begin
         r_kind_mem[w_mem_slot] <= KIND_MEM;
         r_pc_mem[w_mem_slot]   <= pc;
         r_addr_mem[w_mem_slot] <= mem_addr;
         r_data_mem[w_mem_slot] <= mem_data;
         r_seq_mem[w_mem_slot]  <= w_mem_seq;
      end
   end

   always_comb begin
      out_valid = 1'b0;
      out_kind  = '0;
      out_pc    = '0;
      out_addr  = '0;
      out_data  = '0;
      out_seq   = '0;
      if (!w_empty) begin
         out_valid = 1'b1;
         out_kind  = r_kind_mem[r_rptr];
         out_pc    = r_pc_mem[r_rptr];
         out_addr  = r_addr_mem[r_rptr];
         out_data  = r_data_mem[r_rptr];
         out_seq   = r_seq_mem[r_rptr];
      end
   end

   assign count      = r_count;
   assign overflow   = r_overflow;
   assign drop_count = r_drop;

endmodule

// File: tb/tb_exec_trace_fifo.sv
// Bench for exec_trace_fifo: directed vector table, hand-written corner sequences and
// random traffic, all checked against a queue-based model of the trace FIFO.
module tb_exec_trace_fifo;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        trace_en = 1'b0;
   logic [31:0] pc = '0;
   logic        reg_we = 1'b0;
   logic [4:0]  reg_rd = '0;
   logic [31:0] reg_data = '0;
   logic        mem_we = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [1:0]  out_kind;
   logic [31:0] out_pc;
   logic [31:0] out_addr;
   logic [31:0] out_data;
   logic [15:0] out_seq;
   logic [4:0]  count;
   logic        overflow;
   logic [15:0] drop_count;

   exec_trace_fifo #(.DEPTH(DEPTH), .FILTER_X0(1'b1)) dut (
      .clk(clk), .reset(reset), .trace_en(trace_en), .pc(pc),
      .reg_we(reg_we), .reg_rd(reg_rd), .reg_data(reg_data),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
      .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data), .out_seq(out_seq),
      .count(count), .overflow(overflow), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [1:0]  kind;
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] data;
      logic [15:0] seq;
   } ent_t;

   ent_t        m_q[$];
   logic [15:0] m_seq;
   int          m_drop;
   bit          m_ovf;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      m_q.delete();
      m_seq  = '0;
      m_drop = 0;
      m_ovf  = 1'b0;
   endtask

   task automatic model_drop();
      m_ovf = 1'b1;
      if (m_drop < 65535) m_drop++;
   endtask

   // Model update for one rising edge, from the inputs present at that edge.
   task automatic model_edge();
      ent_t e;
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      if (trace_en && reg_we && reg_rd != 5'd0) begin
         if (m_q.size() < DEPTH) begin
            e.kind = 2'b01; e.pc = pc; e.addr = {27'b0, reg_rd}; e.data = reg_data; e.seq = m_seq;
            m_q.push_back(e);
            m_seq++;
         end else model_drop();
      end
      if (trace_en && mem_we) begin
         if (m_q.size() < DEPTH) begin
            e.kind = 2'b10; e.pc = pc; e.addr = mem_addr; e.data = mem_data; e.seq = m_seq;
            m_q.push_back(e);
            m_seq++;
         end else model_drop();
      end
   endtask

   task automatic cmp_model(input string tag);
      ent_t h;
      h = '{kind: 2'b00, pc: 32'h0, addr: 32'h0, data: 32'h0, seq: 16'h0};
      if (m_q.size() > 0) h = m_q[0];
      chk({tag, ".valid"}, 64'(out_valid), 64'(m_q.size() > 0));
      chk({tag, ".kind"},  64'(out_kind),  64'(h.kind));
      chk({tag, ".pc"},    64'(out_pc),    64'(h.pc));
      chk({tag, ".addr"},  64'(out_addr),  64'(h.addr));
      chk({tag, ".data"},  64'(out_data),  64'(h.data));
      chk({tag, ".seq"},   64'(out_seq),   64'(h.seq));
      chk({tag, ".count"}, 64'(count),     64'(m_q.size()));
      chk({tag, ".ovf"},   64'(overflow),  64'(m_ovf));
      chk({tag, ".drop"},  64'(drop_count), 64'(m_drop));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      cmp_model(tag);
   endtask

   task automatic idle_inputs();
      trace_en = 1'b0; pc = '0; reg_we = 1'b0; reg_rd = '0; reg_data = '0;
      mem_we = 1'b0; mem_addr = '0; mem_data = '0;
   endtask

   task automatic set_in(input bit te, input bit rwe, input logic [4:0] rd, input logic [31:0] rdat,
                         input bit mwe, input logic [31:0] ma, input logic [31:0] md,
                         input logic [31:0] p, input bit rdy);
      trace_en = te; reg_we = rwe; reg_rd = rd; reg_data = rdat;
      mem_we = mwe; mem_addr = ma; mem_data = md; pc = p; out_ready = rdy;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      idle_inputs();
      out_ready = 1'b0;
      model_clear();
      #2;
      @(posedge clk);
      #1;
      reset = 1'b1;
      cmp_model("reset");
   endtask

   typedef struct {
      bit          rst;
      bit          te;
      bit          rwe;
      logic [4:0]  rd;
      logic [31:0] rdata;
      bit          mwe;
      logic [31:0] maddr;
      logic [31:0] mdata;
      logic [31:0] pc;
      bit          rdy;
      bit          ev;
      logic [1:0]  ek;
      logic [31:0] epc;
      logic [31:0] eaddr;
      logic [31:0] edata;
      logic [15:0] eseq;
      int          ecount;
      int          edrop;
   } vec_t;

   vec_t tbl[10];

   initial begin
      tbl[0] = '{1, 1, 1, 5'd5, 32'hDEADBEEF, 0, 32'h0, 32'h0, 32'h10, 0,
                 1, 2'b01, 32'h10, 32'h5, 32'hDEADBEEF, 16'd0, 1, 0};
      tbl[1] = '{0, 0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0,
                 1, 2'b01, 32'h10, 32'h5, 32'hDEADBEEF, 16'd0, 1, 0};
      tbl[2] = tbl[1];
      tbl[3] = tbl[1];
      tbl[4] = '{0, 0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 1,
                 0, 2'b00, 32'h0, 32'h0, 32'h0, 16'd0, 0, 0};
      tbl[5] = '{1, 1, 1, 5'd1, 32'h11, 1, 32'h2000, 32'h22, 32'h40, 0,
                 1, 2'b01, 32'h40, 32'h1, 32'h11, 16'd0, 2, 0};
      tbl[6] = '{0, 0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 1,
                 1, 2'b10, 32'h40, 32'h2000, 32'h22, 16'd1, 1, 0};
      tbl[7] = tbl[4];
      tbl[8] = '{1, 1, 1, 5'd0, 32'h99, 0, 32'h0, 32'h0, 32'h50, 0,
                 0, 2'b00, 32'h0, 32'h0, 32'h0, 16'd0, 0, 0};
      tbl[9] = '{0, 1, 1, 5'd3, 32'h33, 0, 32'h0, 32'h0, 32'h54, 0,
                 1, 2'b01, 32'h54, 32'h3, 32'h33, 16'd0, 1, 0};

      model_clear();
      do_reset();

      // Directed vector table
      for (int i = 0; i < 10; i++) begin
         if (tbl[i].rst) do_reset();
         set_in(tbl[i].te, tbl[i].rwe, tbl[i].rd, tbl[i].rdata, tbl[i].mwe,
                tbl[i].maddr, tbl[i].mdata, tbl[i].pc, tbl[i].rdy);
         step($sformatf("vec%0d", i));
         chk($sformatf("vec%0d.tvalid", i), 64'(out_valid), 64'(tbl[i].ev));
         chk($sformatf("vec%0d.tkind", i),  64'(out_kind),  64'(tbl[i].ek));
         chk($sformatf("vec%0d.tpc", i),    64'(out_pc),    64'(tbl[i].epc));
         chk($sformatf("vec%0d.taddr", i),  64'(out_addr),  64'(tbl[i].eaddr));
         chk($sformatf("vec%0d.tdata", i),  64'(out_data),  64'(tbl[i].edata));
         chk($sformatf("vec%0d.tseq", i),   64'(out_seq),   64'(tbl[i].eseq));
         chk($sformatf("vec%0d.tcount", i), 64'(count),     64'(tbl[i].ecount));
         chk($sformatf("vec%0d.tdrop", i),  64'(drop_count), 64'(tbl[i].edrop));
         idle_inputs();
      end

      // Fill to DEPTH, then overflow with three more reg events
      do_reset();
      for (int i = 0; i < DEPTH + 3; i++) begin
         set_in(1, 1, 5'((i % 31) + 1), 32'(i), 0, 32'h0, 32'h0, 32'h100 + 32'(4 * i), 0);
         step($sformatf("fill%0d", i));
      end
      chk("full.count", 64'(count), 64'd16);
      chk("full.ovf",   64'(overflow), 64'd1);
      chk("full.drop",  64'(drop_count), 64'd3);
      chk("full.seq",   64'(out_seq), 64'd0);

      // Full with a pop: reg accepted into the freed slot, mem dropped
      set_in(1, 1, 5'd9, 32'hAAAA, 1, 32'h3000, 32'hBBBB, 32'h200, 1);
      step("fullpop");
      chk("fullpop.count", 64'(count), 64'd16);
      chk("fullpop.drop",  64'(drop_count), 64'd4);
      chk("fullpop.seq",   64'(out_seq), 64'd1);
      idle_inputs();
      out_ready = 1'b0;
      step("fullpop.hold");

      // Asynchronous reset with eight entries queued
      do_reset();
      for (int i = 0; i < 8; i++) begin
         set_in(1, 1, 5'd2, 32'h500 + 32'(i), 0, 32'h0, 32'h0, 32'h300 + 32'(4 * i), 0);
         step($sformatf("pre_rst%0d", i));
      end
      chk("pre_rst.count", 64'(count), 64'd8);
      idle_inputs();
      #2;
      reset = 1'b0;
      #1;
      chk("arst.valid", 64'(out_valid), 64'd0);
      chk("arst.kind",  64'(out_kind), 64'd0);
      chk("arst.pc",    64'(out_pc), 64'd0);
      chk("arst.addr",  64'(out_addr), 64'd0);
      chk("arst.data",  64'(out_data), 64'd0);
      chk("arst.seq",   64'(out_seq), 64'd0);
      chk("arst.count", 64'(count), 64'd0);
      model_clear();
      @(posedge clk);
      #1;
      reset = 1'b1;
      set_in(1, 1, 5'd7, 32'h77, 0, 32'h0, 32'h0, 32'h400, 0);
      step("post_rst");
      chk("post_rst.seq",   64'(out_seq), 64'd0);
      chk("post_rst.count", 64'(count), 64'd1);
      idle_inputs();

      // Random traffic with varying consumer pressure
      do_reset();
      for (int i = 0; i < 900; i++) begin
         int rdy_pct;
         rdy_pct = (i < 300) ? 25 : (i < 600) ? 80 : 50;
         set_in(($urandom % 8) != 0, $urandom % 2, 5'($urandom % 32), $urandom,
                $urandom % 2, $urandom, $urandom, $urandom, ($urandom % 100) < 32'(rdy_pct));
         step($sformatf("rnd%0d", i));
      end
      idle_inputs();
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) step($sformatf("drain%0d", i));
      chk("drain.count", 64'(count), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/exec_trace_fifo.md
Name: exec_trace_fifo

Overview:
- Captures CPU commit events (register-file writes and data-memory writes) from the multicycle RV32I core.
- Buffers the events in an ordered FIFO and hands them downstream over a valid/ready port.
- The simulation bench and the on-board debug drain consume that port.
- Sits directly downstream of the core's writeback and memory-write signals and observes them only; it never stalls the CPU.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of two and at least 2.
- FILTER_X0, 1, when 1, register writes with rd = 0 are not recorded.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- trace_en  in  1  capture enable; when 0, no events are recorded.
- pc  in  32  PC of the instruction producing the event(s) this cycle.
- reg_we  in  1  register-file write strobe.
- reg_rd  in  5  destination register address.
- reg_data  in  32  register write data.
- mem_we  in  1  data-memory write strobe.
- mem_addr  in  32  memory write address.
- mem_data  in  32  memory write data.
- out_valid  out  1  head entry present.
- out_ready  in  1  consumer accepts the head entry.
- out_kind  out  2  01 = register event, 10 = memory event, 00 when empty.
- out_pc  out  32  head entry PC.
- out_addr  out  32  for a register event, {27'b0, rd}; for a memory event, mem_addr.
- out_data  out  32  head entry data.
- out_seq  out  16  head entry sequence number.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky flag: at least one event was dropped since reset.
- drop_count  out  16  dropped-event count, saturating at 16'hFFFF.

Behaviour:
- Reset (reset = 0, asynchronous):
  - Clears the pointers, count, sequence counter, overflow and drop_count.
  - out_valid = 0 and all out_* = 0.
  - An in-flight push or pop is discarded; the next sequence number after reset is 0.
- Event qualification:
  - A reg event is reg_we & trace_en, and additionally rd != 0 when FILTER_X0 = 1.
  - A mem event is mem_we & trace_en.
  - All inputs are sampled on the rising edge.
- Dual push:
  - Up to two entries are written per cycle.
  - When both events are present, the reg entry is written first (lower slot, lower seq) and the mem entry second.
  - Both entries carry the same pc.
- Pop: occurs when out_valid & out_ready at the rising edge.
- Capacity check:
  - An entry is accepted if count − pop + accepted_so_far < DEPTH.
  - The check is evaluated in order: reg first, then mem.
  - A pop in the same cycle frees its slot for that cycle's pushes.
- Overflow:
  - Each rejected event increments drop_count, saturating at 16'hFFFF, and sets overflow.
  - If both events are rejected, drop_count increases by 2 (still saturating).
  - Dropped events do not consume a sequence number.
- Sequence numbers: the sequence counter increments by the number of accepted entries (0, 1 or 2) per cycle and wraps from 16'hFFFF to 0.
- Latency and output timing:
  - First-word fall-through.
  - An event accepted at edge N is visible at the outputs with out_valid = 1 in the cycle after edge N.
  - out_* remain stable while out_valid & !out_ready.
  - When empty, out_valid = 0 and out_kind/out_pc/out_addr/out_data/out_seq = 0.
- Count:
  - count_next = count + accepted − pop; never exceeds DEPTH.
  - A pop when empty is a no-op.
- Pointers: the read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; full and empty are derived from count.
- trace_en deasserted: no pushes, no drops counted; popping continues normally.

Test Plan:
- Reset then a single reg event (rd = 5, data 0xDEADBEEF, pc 0x10) with out_ready = 0:
  - Next cycle: out_valid = 1, kind 01, addr 0x5, data 0xDEADBEEF, pc 0x10, seq 0, count 1.
  - Outputs hold across 3 stall cycles.
- Same cycle: reg (rd 1, 0x11) and mem (addr 0x2000, 0x22), pc 0x40:
  - count becomes 2.
  - Drains in order: reg entry with seq 0, then mem entry with seq 1.
- FILTER_X0 = 1, reg write to rd = 0, then rd = 3:
  - Only the rd = 3 entry appears, with seq 0.
  - drop_count stays 0.
- Fill DEPTH = 16 with out_ready = 0, then push 3 more reg events:
  - count stays 16, overflow = 1, drop_count = 3.
  - The head is still seq 0.
- Full FIFO with out_ready = 1 and a simultaneous reg+mem event:
  - Pop frees one slot; the reg entry is accepted and the mem entry is dropped.
  - count stays 16, drop_count increases by 1.
- Assert reset low mid-stream with 8 entries queued:
  - All outputs return to 0 immediately (asynchronously).
  - After release, the first new event has seq 0 and count = 1.
